// File: rtl/rvh_ptw_mem_bridge_pkg.sv
// Shared MMU definitions for the page-table-walker memory bridge: FSM states
// and line-geometry helpers.
package rvh_ptw_mem_bridge_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MREQ  = 2'd1,
      MWAIT = 2'd2,
      RESP  = 2'd3
   } ptw_bridge_state_e;

   localparam int DEFAULT_LINE_WIDTH = 256;

   // Number of byte-offset bits inside one memory line of the given width.
   function automatic int line_offset_width(input int line_width);
      return $clog2(line_width / 8);
   endfunction

   localparam int LINE_OFFSET_WIDTH = line_offset_width(DEFAULT_LINE_WIDTH);

endpackage

// File: rtl/rvh_ptw_mem_bridge.sv
// PTW-to-memory bridge: one outstanding PTE read, served from a single-line
// buffer on a hit or fetched as a full line from memory on a miss.
module rvh_ptw_mem_bridge
   import rvh_ptw_mem_bridge_pkg::*;
#(
   parameter int PADDR_WIDTH  = 56,
   parameter int PTW_ID_WIDTH = 1,
   parameter int PTE_WIDTH    = 64,
   parameter int LINE_WIDTH   = 256
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    ptw_walk_req_vld_i,
   input  logic [PTW_ID_WIDTH-1:0] ptw_walk_req_id_i,
   input  logic [PADDR_WIDTH-1:0]  ptw_walk_req_addr_i,
   output logic                    ptw_walk_req_rdy_o,
   output logic                    ptw_walk_resp_vld_o,
   output logic [PTW_ID_WIDTH-1:0] ptw_walk_resp_id_o,
   output logic [PTE_WIDTH-1:0]    ptw_walk_resp_pte_o,
   input  logic                    ptw_walk_resp_rdy_i,
   output logic                    mem_req_vld_o,
   output logic [PADDR_WIDTH-1:0]  mem_req_addr_o,
   input  logic                    mem_req_rdy_i,
   input  logic                    mem_resp_vld_i,
   input  logic [LINE_WIDTH-1:0]   mem_resp_data_i,
   input  logic                    mem_resp_err_i,
   output logic                    mem_resp_rdy_o,
   input  logic                    flush_i
);

   localparam int OFF_W   = line_offset_width(LINE_WIDTH);
   localparam int IDX_W   = OFF_W - 3;
   localparam int NUM_PTE = 1 << IDX_W;
   localparam int TAG_W   = PADDR_WIDTH - OFF_W;

   ptw_bridge_state_e        state_reg;
   logic                     req_rdy_reg;
   logic                     resp_vld_reg;
   logic [PTW_ID_WIDTH-1:0]  resp_id_reg;
   logic [PTE_WIDTH-1:0]     resp_pte_reg;
   logic                     mem_req_vld_reg;
   logic [PADDR_WIDTH-1:0]   mem_req_addr_reg;
   logic                     mem_resp_rdy_reg;
   logic [TAG_W-1:0]         tag_reg;
   logic [IDX_W-1:0]         idx_reg;
   logic                     pend_flush_reg;
   logic                     buf_vld_reg;
   logic [TAG_W-1:0]         buf_tag_reg;
   logic [LINE_WIDTH-1:0]    buf_line_reg;

   logic [PTE_WIDTH-1:0]     buf_ptes [NUM_PTE];
   logic [PTE_WIDTH-1:0]     mem_ptes [NUM_PTE];

   for (genvar gi = 0; gi < NUM_PTE; gi++) begin : g_pte
      assign buf_ptes[gi] = buf_line_reg[gi*PTE_WIDTH +: PTE_WIDTH];
      assign mem_ptes[gi] = mem_resp_data_i[gi*PTE_WIDTH +: PTE_WIDTH];
   end

   logic             req_fire;
   logic             req_misaligned;
   logic             req_hit;
   logic [TAG_W-1:0] req_tag;
   logic [IDX_W-1:0] req_idx;

   assign req_tag        = ptw_walk_req_addr_i[PADDR_WIDTH-1:OFF_W];
   assign req_idx        = ptw_walk_req_addr_i[OFF_W-1:3];
   assign req_fire       = ptw_walk_req_vld_i & req_rdy_reg;
   assign req_misaligned = |ptw_walk_req_addr_i[2:0];
   assign req_hit        = buf_vld_reg && (buf_tag_reg == req_tag) && !flush_i;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_reg        <= IDLE;
         req_rdy_reg      <= 1'b1;
         resp_vld_reg     <= 1'b0;
         resp_id_reg      <= '0;
         resp_pte_reg     <= '0;
         mem_req_vld_reg  <= 1'b0;
         mem_req_addr_reg <= '0;
         mem_resp_rdy_reg <= 1'b0;
         pend_flush_reg   <= 1'b0;
         buf_vld_reg      <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (req_fire) begin
                  req_rdy_reg    <= 1'b0;
                  resp_id_reg    <= ptw_walk_req_id_i;
                  tag_reg        <= req_tag;
                  idx_reg        <= req_idx;
                  pend_flush_reg <= flush_i;
                  if (req_misaligned) begin
                     resp_pte_reg <= '0;
                     resp_vld_reg <= 1'b1;
                     state_reg    <= RESP;
                  end else if (req_hit) begin
                     resp_pte_reg <= buf_ptes[req_idx];
                     resp_vld_reg <= 1'b1;
                     state_reg    <= RESP;
                  end else begin
                     mem_req_addr_reg <= {req_tag, {OFF_W{1'b0}}};
                     mem_req_vld_reg  <= 1'b1;
                     state_reg        <= MREQ;
                  end
               end
            end
            MREQ: begin
               if (mem_req_rdy_i) begin
                  mem_req_vld_reg  <= 1'b0;
                  mem_resp_rdy_reg <= 1'b1;
                  state_reg        <= MWAIT;
               end
            end
            MWAIT: begin
               if (mem_resp_vld_i) begin
                  mem_resp_rdy_reg <= 1'b0;
                  resp_vld_reg     <= 1'b1;
                  state_reg        <= RESP;
                  if (mem_resp_err_i) begin
                     resp_pte_reg <= '0;
                     buf_vld_reg  <= 1'b0;
                  end else begin
                     resp_pte_reg <= mem_ptes[idx_reg];
                     // A flush since acceptance makes this line possibly stale.
                     if (!pend_flush_reg) begin
                        buf_vld_reg  <= 1'b1;
                        buf_tag_reg  <= tag_reg;
                        buf_line_reg <= mem_resp_data_i;
                     end
                  end
               end
            end
            RESP: begin
               if (ptw_walk_resp_rdy_i) begin
                  resp_vld_reg <= 1'b0;
                  req_rdy_reg  <= 1'b1;
                  state_reg    <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
         // Placed last so a coincident flush overrides any fill above.
         if (flush_i) begin
            buf_vld_reg    <= 1'b0;
            pend_flush_reg <= 1'b1;
         end
      end
   end

   assign ptw_walk_req_rdy_o  = req_rdy_reg;
   assign ptw_walk_resp_vld_o = resp_vld_reg;
   assign ptw_walk_resp_id_o  = resp_id_reg;
   assign ptw_walk_resp_pte_o = resp_pte_reg;
   assign mem_req_vld_o       = mem_req_vld_reg;
   assign mem_req_addr_o      = mem_req_addr_reg;
   assign mem_resp_rdy_o      = mem_resp_rdy_reg;

endmodule

// File: tb/tb_rvh_ptw_mem_bridge.sv
// Directed plus randomized walk traffic against a line-buffer reference model.
module tb_rvh_ptw_mem_bridge;

   logic          clk = 1'b0;
   logic          rstn;
   logic          req_vld;
   logic [0:0]    req_id;
   logic [55:0]   req_addr;
   logic          req_rdy;
   logic          resp_vld;
   logic [0:0]    resp_id;
   logic [63:0]   resp_pte;
   logic          resp_rdy;
   logic          mreq_vld;
   logic [55:0]   mreq_addr;
   logic          mreq_rdy;
   logic          mresp_vld;
   logic [255:0]  mresp_data;
   logic          mresp_err;
   logic          mresp_rdy;
   logic          flush;

   int n_checks = 0;
   int n_pass   = 0;
   int hs_cnt   = 0;

   // Reference model of the line buffer: valid flag and buffered line address.
   bit            m_valid = 0;
   logic [55:0]   m_line  = '0;

   always #5 clk = ~clk;

   always @(posedge clk) if (mreq_vld && mreq_rdy) hs_cnt <= hs_cnt + 1;

   rvh_ptw_mem_bridge #(
      .PADDR_WIDTH (56),
      .PTW_ID_WIDTH(1),
      .PTE_WIDTH   (64),
      .LINE_WIDTH  (256)
   ) dut (
      .clk                (clk),
      .rstn               (rstn),
      .ptw_walk_req_vld_i (req_vld),
      .ptw_walk_req_id_i  (req_id),
      .ptw_walk_req_addr_i(req_addr),
      .ptw_walk_req_rdy_o (req_rdy),
      .ptw_walk_resp_vld_o(resp_vld),
      .ptw_walk_resp_id_o (resp_id),
      .ptw_walk_resp_pte_o(resp_pte),
      .ptw_walk_resp_rdy_i(resp_rdy),
      .mem_req_vld_o      (mreq_vld),
      .mem_req_addr_o     (mreq_addr),
      .mem_req_rdy_i      (mreq_rdy),
      .mem_resp_vld_i     (mresp_vld),
      .mem_resp_data_i    (mresp_data),
      .mem_resp_err_i     (mresp_err),
      .mem_resp_rdy_o     (mresp_rdy),
      .flush_i            (flush)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Memory contents: PTE i of a line is derived from the line address.
   function automatic logic [63:0] mem_word(input logic [55:0] line, input int i);
      if (line == 56'h8000_1000 && i == 1) return 64'h20000CF;
      return {line[31:0], 24'h0C0_000 | 24'(i), 8'h5F};
   endfunction

   function automatic logic [255:0] mem_line(input logic [55:0] line);
      logic [255:0] d;
      for (int i = 0; i < 4; i++) d[i*64 +: 64] = mem_word(line, i);
      return d;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic walk(input logic [55:0] addr, input logic [0:0] id, input int mstall,
                       input int rstall, input bit err, input bit flush_mw);
      logic [55:0] line;
      logic [63:0] exp_pte;
      bit          mis, hit;
      int          hs0, cyc;
      line    = {addr[55:5], 5'b0};
      mis     = (addr[2:0] != 3'b0);
      hit     = !mis && m_valid && (m_line == line);
      exp_pte = (mis || (!hit && err)) ? 64'h0 : mem_word(line, int'(addr[4:3]));
      hs0     = hs_cnt;
      cyc     = 0;
      while (!req_rdy && cyc < 50) begin
         tick();
         cyc++;
      end
      check("req_rdy_idle", 64'(req_rdy), 64'd1);
      req_vld  = 1'b1;
      req_addr = addr;
      req_id   = id;
      tick();
      req_vld  = 1'b0;
      req_addr = {$urandom, $urandom} & 56'hFF_FFFF_FFFF_FFFF;
      req_id   = ~id;
      check("req_rdy_busy", 64'(req_rdy), 64'd0);
      if (hit || mis) begin
         check("no_mreq", 64'(mreq_vld), 64'd0);
         check("fast_resp_vld", 64'(resp_vld), 64'd1);
      end else begin
         check("mreq_vld", 64'(mreq_vld), 64'd1);
         check("mreq_addr", 64'(mreq_addr), 64'(line));
         for (int i = 0; i < mstall; i++) begin
            tick();
            check("mreq_hold_vld", 64'(mreq_vld), 64'd1);
            check("mreq_hold_addr", 64'(mreq_addr), 64'(line));
         end
         mreq_rdy = 1'b1;
         tick();
         mreq_rdy = 1'b0;
         check("mwait_rdy", 64'(mresp_rdy), 64'd1);
         check("mreq_drop", 64'(mreq_vld), 64'd0);
         if (flush_mw) begin
            flush = 1'b1;
            tick();
            flush = 1'b0;
         end
         mresp_vld  = 1'b1;
         mresp_data = mem_line(line);
         mresp_err  = err;
         tick();
         mresp_vld  = 1'b0;
         mresp_err  = 1'b0;
         mresp_data = '0;
         check("resp_vld", 64'(resp_vld), 64'd1);
         check("mresp_rdy_drop", 64'(mresp_rdy), 64'd0);
      end
      check("resp_id", 64'(resp_id), 64'(id));
      check("resp_pte", resp_pte, exp_pte);
      check("vld_exclusive", 64'(mreq_vld && resp_vld), 64'd0);
      for (int i = 0; i < rstall; i++) begin
         tick();
         check("resp_hold_vld", 64'(resp_vld), 64'd1);
         check("resp_hold_id", 64'(resp_id), 64'(id));
         check("resp_hold_pte", resp_pte, exp_pte);
         check("resp_hold_no_accept", 64'(req_rdy), 64'd0);
      end
      resp_rdy = 1'b1;
      tick();
      resp_rdy = 1'b0;
      check("resp_done", 64'(resp_vld), 64'd0);
      check("req_rdy_back", 64'(req_rdy), 64'd1);
      check("mreq_handshakes", 64'(hs_cnt - hs0), (hit || mis) ? 64'd0 : 64'd1);
      if (!hit && !mis) begin
         if (err || flush_mw) m_valid = 0;
         else begin
            m_valid = 1;
            m_line  = line;
         end
      end
      $display("walk addr=%h id=%0d hit=%0d misaligned=%0d err=%0d flush=%0d pte=%h",
               addr, id, hit, mis, err, flush_mw, resp_pte);
   endtask

   initial begin
      rstn = 1'b0; req_vld = 1'b0; req_id = '0; req_addr = '0; resp_rdy = 1'b0;
      mreq_rdy = 1'b0; mresp_vld = 1'b0; mresp_data = '0; mresp_err = 1'b0; flush = 1'b0;
      repeat (3) tick();
      check("rst_req_rdy", 64'(req_rdy), 64'd1);
      check("rst_resp_vld", 64'(resp_vld), 64'd0);
      check("rst_mreq_vld", 64'(mreq_vld), 64'd0);
      check("rst_mresp_rdy", 64'(mresp_rdy), 64'd0);
      check("rst_pte", resp_pte, 64'd0);
      check("rst_id", 64'(resp_id), 64'd0);
      check("rst_mreq_addr", 64'(mreq_addr), 64'd0);
      rstn = 1'b1;
      tick();

      walk(56'h8000_1008, 1'b1, 0, 0, 0, 0);   // miss, PTE[1] = 0x20000CF
      check("miss_pte_const", resp_pte, 64'h20000CF);
      walk(56'h8000_1018, 1'b0, 0, 0, 0, 0);   // hit on buffered line
      walk(56'h8000_2008, 1'b1, 1, 1, 0, 1);   // flush while in MWAIT
      walk(56'h8000_2010, 1'b0, 0, 0, 0, 0);   // same line must miss again
      walk(56'h8000_3000, 1'b1, 0, 0, 1, 0);   // bus error
      walk(56'h8000_3008, 1'b0, 0, 0, 0, 0);   // same line must miss again
      walk(56'h8000_4010, 1'b1, 5, 3, 0, 0);   // backpressure on both sides
      walk(56'h8000_1004, 1'b0, 0, 0, 0, 0);   // misaligned

      // Reset while waiting for memory, then a stray line response in IDLE.
      req_vld = 1'b1; req_addr = 56'h8000_5000; req_id = 1'b1;
      tick();
      req_vld = 1'b0; mreq_rdy = 1'b1;
      tick();
      mreq_rdy = 1'b0;
      check("pre_rst_mwait", 64'(mresp_rdy), 64'd1);
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      m_valid = 0;
      check("midrst_req_rdy", 64'(req_rdy), 64'd1);
      check("midrst_mresp_rdy", 64'(mresp_rdy), 64'd0);
      check("midrst_resp_vld", 64'(resp_vld), 64'd0);
      mresp_vld = 1'b1; mresp_data = mem_line(56'h8000_5000);
      tick();
      mresp_vld = 1'b0; mresp_data = '0;
      check("stray_resp_vld", 64'(resp_vld), 64'd0);
      check("stray_req_rdy", 64'(req_rdy), 64'd1);
      walk(56'h8000_4010, 1'b0, 0, 0, 0, 0);   // buffer was cleared by reset

      for (int n = 0; n < 40; n++) begin
         logic [55:0] a;
         a = 56'h8000_1000 + 56'($urandom_range(0, 3) * 32) + 56'($urandom_range(0, 3) * 8);
         if ($urandom_range(0, 7) == 0) a = a + 56'd4;
         walk(a, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
